// File: rtl/pp_addr_table_pkg.sv
// Shared definitions for the pp address table: API address map, ID constants,
// CTRL/STATUS bit positions and the lookup engine state encoding.
package pp_addr_table_pkg;

  localparam logic [11:0] ADDR_NAME0       = 12'h000;
  localparam logic [11:0] ADDR_NAME1       = 12'h001;
  localparam logic [11:0] ADDR_VERSION     = 12'h002;
  localparam logic [11:0] ADDR_CTRL        = 12'h008;
  localparam logic [11:0] ADDR_STATUS      = 12'h009;
  localparam logic [11:0] ADDR_STAGE_INDEX = 12'h00A;
  localparam logic [11:0] ADDR_STAGE_VALID = 12'h00B;
  localparam logic [11:0] ADDR_STAGE_DATA  = 12'h010;
  localparam logic [11:0] ADDR_CNT_LOOKUPS = 12'h020;
  localparam logic [11:0] ADDR_CNT_HITS    = 12'h021;
  localparam logic [11:0] ADDR_ENTRY_BASE  = 12'h100;

  // Each committed entry occupies an 8-word window; the last word holds its valid bit.
  localparam int ENTRY_STRIDE     = 8;
  localparam int ENTRY_VALID_WORD = 7;

  localparam logic [31:0] NAME0_VAL    = 32'h70705f61;
  localparam logic [31:0] NAME1_VAL    = 32'h64647274;
  localparam logic [31:0] VERSION_VAL  = 32'h302e3230;
  localparam logic [31:0] READ_DEFAULT = 32'hbeefbeef;

  localparam int CTRL_COMMIT_BIT    = 0;
  localparam int CTRL_CLEAR_BIT     = 1;
  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_BUSY_BIT    = 1;

  typedef enum logic [1:0] {
    SCAN_IDLE = 2'd0,
    SCAN_RUN  = 2'd1,
    SCAN_DONE = 2'd2
  } scan_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pp_addr_table_if.sv
// Bus bundle for pp_addr_table: 32-bit cs/we register API plus the
// lookup request/result path of the packet parser.
interface pp_addr_table_if #(
  parameter int NUM_ENTRIES = 8,
  parameter int ENTRY_WORDS = 4
);
  localparam int KEY_W = 32 * ENTRY_WORDS;
  localparam int IDX_W = pp_addr_table_pkg::idx_width(NUM_ENTRIES);

  logic             cs;
  logic             we;
  logic [11:0]      address;
  logic [31:0]      write_data;
  logic [31:0]      read_data;
  logic             ready;
  logic             lookup_start;
  logic [KEY_W-1:0] lookup_addr;
  logic             lookup_done;
  logic             lookup_hit;
  logic [IDX_W-1:0] lookup_index;

  modport master (
    output cs, we, address, write_data, lookup_start, lookup_addr,
    input  read_data, ready, lookup_done, lookup_hit, lookup_index
  );

  modport slave (
    input  cs, we, address, write_data, lookup_start, lookup_addr,
    output read_data, ready, lookup_done, lookup_hit, lookup_index
  );
endinterface

// File: rtl/pp_addr_scan.sv
// Sequential lookup engine: walks the table one entry per cycle from index 0
// and reports the first valid entry whose data equals the captured key.
module pp_addr_scan
  import pp_addr_table_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int ENTRY_WORDS = 4,
  localparam int KEY_W = 32 * ENTRY_WORDS,
  localparam int IDX_W = idx_width(NUM_ENTRIES)
) (
  input  logic                              clk,
  input  logic                              areset,
  input  logic                              start_i,
  input  logic [KEY_W-1:0]                  key_i,
  input  logic [NUM_ENTRIES-1:0][KEY_W-1:0] entry_data_i,
  input  logic [NUM_ENTRIES-1:0]            entry_valid_i,
  output logic                              accept_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              hit_o,
  output logic [IDX_W-1:0]                  index_o
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  scan_state_e      state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             done_q, done_d;
  logic             hit_q, hit_d;
  logic             match;

  assign match = entry_valid_i[idx_q] && (entry_data_i[idx_q] == key_q);

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    idx_d    = idx_q;
    index_d  = index_q;
    hit_d    = hit_q;
    done_d   = 1'b0;
    accept_o = 1'b0;
    case (state_q)
      SCAN_IDLE: begin
        if (start_i) begin
          accept_o = 1'b1;
          key_d    = key_i;
          idx_d    = '0;
          hit_d    = 1'b0;
          index_d  = '0;
          state_d  = SCAN_RUN;
        end
      end
      SCAN_RUN: begin
        if (match) begin
          hit_d   = 1'b1;
          index_d = idx_q;
          done_d  = 1'b1;
          state_d = SCAN_DONE;
        end else if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = SCAN_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SCAN_DONE: state_d = SCAN_IDLE;
      default:   state_d = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= SCAN_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      index_q <= '0;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      index_q <= index_d;
      hit_q   <= hit_d;
      done_q  <= done_d;
    end
  end

  assign busy_o  = (state_q != SCAN_IDLE);
  assign done_o  = done_q;
  assign hit_o   = hit_q;
  assign index_o = index_q;

endmodule

// File: rtl/pp_addr_table.sv
// API-mapped local address table: staging buffer with atomic commit, registered
// read-back, lookup/hit counters and a sequential lookup engine for the parser.
module pp_addr_table
  import pp_addr_table_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int ENTRY_WORDS = 4,
  parameter int CNT_W       = 32
) (
  input  logic           clk,
  input  logic           areset,
  pp_addr_table_if.slave bus
);
  localparam int KEY_W = 32 * ENTRY_WORDS;
  localparam int IDX_W = idx_width(NUM_ENTRIES);

  logic [31:0]                                 stage_index_q, stage_index_d;
  logic                                        stage_valid_q, stage_valid_d;
  logic [0:ENTRY_WORDS-1][31:0]                stage_data_q, stage_data_d;
  logic [NUM_ENTRIES-1:0][0:ENTRY_WORDS-1][31:0] entry_data_q, entry_data_d;
  logic [NUM_ENTRIES-1:0]                      entry_valid_q, entry_valid_d;
  logic                                        commit_pending_q, commit_pending_d;
  logic [CNT_W-1:0]                            cnt_lookups_q, cnt_lookups_d;
  logic [CNT_W-1:0]                            cnt_hits_q, cnt_hits_d;
  logic [31:0]                                 read_data_q, read_data_d;
  logic                                        ready_q;

  logic             wr, commit_wr, clear_wr, do_copy;
  logic             scan_accept, scan_busy, scan_done, scan_hit;
  logic [IDX_W-1:0] scan_index;

  assign wr        = bus.cs && bus.we;
  assign commit_wr = wr && (bus.address == ADDR_CTRL) && bus.write_data[CTRL_COMMIT_BIT];
  assign clear_wr  = wr && (bus.address == ADDR_CTRL) && bus.write_data[CTRL_CLEAR_BIT];
  // A commit issued while the engine is busy is parked and replayed on the first idle cycle.
  assign do_copy   = (commit_wr || commit_pending_q) && !scan_busy;

  always_comb begin
    stage_index_d    = stage_index_q;
    stage_valid_d    = stage_valid_q;
    stage_data_d     = stage_data_q;
    entry_data_d     = entry_data_q;
    entry_valid_d    = entry_valid_q;
    commit_pending_d = commit_pending_q;
    if (wr) begin
      if (bus.address == ADDR_STAGE_INDEX) stage_index_d = bus.write_data;
      if (bus.address == ADDR_STAGE_VALID) stage_valid_d = bus.write_data[0];
      for (int w = 0; w < ENTRY_WORDS; w++) begin
        if (bus.address == ADDR_STAGE_DATA + 12'(w)) stage_data_d[w] = bus.write_data;
      end
    end
    // Out-of-range STAGE_INDEX matches no entry, so the copy is silently dropped.
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      if (do_copy && (stage_index_q == 32'(e))) begin
        entry_data_d[e]  = stage_data_q;
        entry_valid_d[e] = stage_valid_q;
      end
    end
    if (do_copy)        commit_pending_d = 1'b0;
    else if (commit_wr) commit_pending_d = 1'b1;
  end

  always_comb begin
    cnt_lookups_d = cnt_lookups_q;
    cnt_hits_d    = cnt_hits_q;
    if (clear_wr) begin
      cnt_lookups_d = '0;
      cnt_hits_d    = '0;
    end else begin
      if (scan_accept)           cnt_lookups_d = cnt_lookups_q + CNT_W'(1);
      if (scan_done && scan_hit) cnt_hits_d    = cnt_hits_q + CNT_W'(1);
    end
  end

  always_comb begin
    read_data_d = '0;
    if (bus.cs && !bus.we) begin
      read_data_d = READ_DEFAULT;
      case (bus.address)
        ADDR_NAME0:       read_data_d = NAME0_VAL;
        ADDR_NAME1:       read_data_d = NAME1_VAL;
        ADDR_VERSION:     read_data_d = VERSION_VAL;
        ADDR_CTRL:        read_data_d = '0;
        ADDR_STATUS: begin
          read_data_d                     = '0;
          read_data_d[STATUS_PENDING_BIT] = commit_pending_q;
          read_data_d[STATUS_BUSY_BIT]    = scan_busy;
        end
        ADDR_STAGE_INDEX: read_data_d = stage_index_q;
        ADDR_STAGE_VALID: read_data_d = {31'b0, stage_valid_q};
        ADDR_CNT_LOOKUPS: read_data_d = 32'(cnt_lookups_q);
        ADDR_CNT_HITS:    read_data_d = 32'(cnt_hits_q);
        default: begin
          for (int w = 0; w < ENTRY_WORDS; w++) begin
            if (bus.address == ADDR_STAGE_DATA + 12'(w)) read_data_d = stage_data_q[w];
          end
          for (int e = 0; e < NUM_ENTRIES; e++) begin
            for (int w = 0; w < ENTRY_WORDS; w++) begin
              if (bus.address == ADDR_ENTRY_BASE + 12'(ENTRY_STRIDE * e + w))
                read_data_d = entry_data_q[e][w];
            end
            if (bus.address == ADDR_ENTRY_BASE + 12'(ENTRY_STRIDE * e + ENTRY_VALID_WORD))
              read_data_d = {31'b0, entry_valid_q[e]};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      stage_index_q    <= '0;
      stage_valid_q    <= 1'b0;
      stage_data_q     <= '0;
      entry_data_q     <= '0;
      entry_valid_q    <= '0;
      commit_pending_q <= 1'b0;
      cnt_lookups_q    <= '0;
      cnt_hits_q       <= '0;
      read_data_q      <= '0;
      ready_q          <= 1'b0;
    end else begin
      stage_index_q    <= stage_index_d;
      stage_valid_q    <= stage_valid_d;
      stage_data_q     <= stage_data_d;
      entry_data_q     <= entry_data_d;
      entry_valid_q    <= entry_valid_d;
      commit_pending_q <= commit_pending_d;
      cnt_lookups_q    <= cnt_lookups_d;
      cnt_hits_q       <= cnt_hits_d;
      read_data_q      <= read_data_d;
      ready_q          <= bus.cs;
    end
  end

  pp_addr_scan #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ENTRY_WORDS (ENTRY_WORDS)
  ) u_scan (
    .clk           (clk),
    .areset        (areset),
    .start_i       (bus.lookup_start),
    .key_i         (bus.lookup_addr),
    .entry_data_i  (entry_data_q),
    .entry_valid_i (entry_valid_q),
    .accept_o      (scan_accept),
    .busy_o        (scan_busy),
    .done_o        (scan_done),
    .hit_o         (scan_hit),
    .index_o       (scan_index)
  );

  assign bus.read_data    = read_data_q;
  assign bus.ready        = ready_q;
  assign bus.lookup_done  = scan_done;
  assign bus.lookup_hit   = scan_hit;
  assign bus.lookup_index = scan_index;

endmodule

// File: tb/tb_pp_addr_table.sv
// Bench for pp_addr_table: API map, commit, lookup timing and counters checked
// against an array-based reference table kept in the bench.
module tb_pp_addr_table;
  localparam int N  = 8;
  localparam int W  = 4;
  localparam int KW = 32 * W;

  logic clk = 1'b0;
  logic areset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pp_addr_table_if #(.NUM_ENTRIES(N), .ENTRY_WORDS(W)) bus();

  pp_addr_table #(.NUM_ENTRIES(N), .ENTRY_WORDS(W), .CNT_W(32)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  // Reference table and API-visible state
  logic [KW-1:0] m_data [N];
  bit            m_valid [N];
  logic [31:0]   m_stage_index;
  bit            m_stage_valid;
  logic [KW-1:0] m_stage;
  int unsigned   m_lookups;
  int unsigned   m_hits;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int e = 0; e < N; e++) begin
      m_data[e]  = '0;
      m_valid[e] = 1'b0;
    end
    m_stage_index = '0;
    m_stage_valid = 1'b0;
    m_stage       = '0;
    m_lookups     = 0;
    m_hits        = 0;
  endtask

  task automatic model_commit();
    if (m_stage_index < N) begin
      m_data[m_stage_index]  = m_stage;
      m_valid[m_stage_index] = m_stage_valid;
    end
  endtask

  task automatic model_lookup(input logic [KW-1:0] key, output bit hit, output int idx,
                              output int lat);
    hit = 1'b0;
    idx = 0;
    lat = N + 1;
    for (int e = 0; e < N; e++) begin
      if (!hit && m_valid[e] && m_data[e] == key) begin
        hit = 1'b1;
        idx = e;
        lat = e + 2;
      end
    end
  endtask

  function automatic logic [KW-1:0] rand_key();
    logic [KW-1:0] k;
    for (int w = 0; w < W; w++) k[32*w +: 32] = $urandom;
    return k;
  endfunction

  task automatic api_write(input logic [11:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.address = a; bus.write_data = d;
    tick();
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic api_read(input logic [11:0] a, output logic [31:0] d, output logic rdy);
    bus.cs = 1'b1; bus.we = 1'b0; bus.address = a;
    tick();
    bus.cs = 1'b0;
    d   = bus.read_data;
    rdy = bus.ready;
  endtask

  task automatic stage(input int idx, input bit v, input logic [KW-1:0] key);
    api_write(12'h00A, 32'(idx));
    api_write(12'h00B, {31'b0, v});
    for (int w = 0; w < W; w++) api_write(12'h010 + 12'(w), key[KW-1-32*w -: 32]);
    m_stage_index = 32'(idx);
    m_stage_valid = v;
    m_stage       = key;
  endtask

  task automatic commit();
    api_write(12'h008, 32'h1);
    model_commit();
  endtask

  // Issues one start and returns at the cycle the done pulse is seen.
  task automatic run_lookup(input logic [KW-1:0] key, output int lat, output bit hit,
                            output int idx, output bit ok);
    int t0;
    bus.lookup_addr  = key;
    bus.lookup_start = 1'b1;
    t0 = cyc;
    tick();
    bus.lookup_start = 1'b0;
    bus.lookup_addr  = rand_key();
    ok = 1'b0; lat = 0; hit = 1'b0; idx = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (bus.lookup_done) begin
        ok  = 1'b1;
        lat = cyc - t0;
        hit = bus.lookup_hit;
        idx = int'(bus.lookup_index);
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset();
    logic [11:0] addrs [6] = '{12'h000, 12'h001, 12'h002, 12'h009, 12'h101, 12'h3FF};
    logic [31:0] exps  [6] = '{32'h70705f61, 32'h64647274, 32'h302e3230, 32'h0, 32'h0,
                               32'hbeefbeef};
    logic [31:0] d;
    logic        r;
    areset = 1'b1;
    tick(); tick(); tick();
    areset = 1'b0;
    model_reset();
    checks++;
    if ({bus.read_data, bus.ready, bus.lookup_done, bus.lookup_hit, bus.lookup_index} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%h rdy=%b done=%b hit=%b idx=%0d required all zero",
               bus.read_data, bus.ready, bus.lookup_done, bus.lookup_hit, bus.lookup_index);
    end
    for (int i = 0; i < 6; i++) begin
      api_read(addrs[i], d, r);
      checks++;
      if (d !== exps[i]) begin
        errors++;
        $display("FAIL reset_read[%h]: got %h required %h", addrs[i], d, exps[i]);
      end
      checks++;
      if (r !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready[%h]: got %b required 1", addrs[i], r);
      end
    end
    tick();
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_one_cycle: got %b required 0", bus.ready);
    end
    api_write(12'h000, 32'h0);
    api_read(12'h000, d, r);
    checks++;
    if (d !== 32'h70705f61) begin
      errors++;
      $display("FAIL readonly_name0: got %h required 70705f61", d);
    end
  endtask

  task automatic test_commit_hit();
    logic [KW-1:0] key = 128'h2001_0db8_0000_0000_0000_0000_0000_0001;
    logic [31:0] d;
    logic r;
    int lat, idx;
    bit hit, ok;
    stage(5, 1'b1, key);
    commit();
    for (int w = 0; w < W; w++) begin
      api_read(12'h128 + 12'(w), d, r);
      checks++;
      if (d !== m_data[5][KW-1-32*w -: 32]) begin
        errors++;
        $display("FAIL entry5_word%0d: got %h required %h", w, d, m_data[5][KW-1-32*w -: 32]);
      end
    end
    api_read(12'h12F, d, r);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL entry5_valid: got %h required 1", d);
    end
    run_lookup(key, lat, hit, idx, ok);
    m_lookups++;
    m_hits++;
    checks++;
    if (!ok || lat !== 7 || hit !== 1'b1 || idx !== 5) begin
      errors++;
      $display("FAIL hit_lookup: got ok=%b lat=%0d hit=%b idx=%0d required ok=1 lat=7 hit=1 idx=5",
               ok, lat, hit, idx);
    end
    tick();
    api_read(12'h021, d, r);
    checks++;
    if (d !== 32'd1) begin
      errors++;
      $display("FAIL cnt_hits_after_hit: got %0d required 1", d);
    end
  endtask

  task automatic test_miss();
    logic [KW-1:0] key;
    logic [31:0] d;
    logic r;
    int lat, idx, elat, eidx;
    bit hit, ok, ehit;
    do begin
      key = rand_key();
      model_lookup(key, ehit, eidx, elat);
    end while (ehit);
    run_lookup(key, lat, hit, idx, ok);
    m_lookups++;
    tick();
    checks++;
    if (!ok || lat !== N + 1 || hit !== 1'b0 || idx !== 0) begin
      errors++;
      $display("FAIL miss_lookup: got ok=%b lat=%0d hit=%b idx=%0d required ok=1 lat=%0d hit=0 idx=0",
               ok, lat, hit, idx, N + 1);
    end
    api_read(12'h020, d, r);
    checks++;
    if (d !== 32'(m_lookups)) begin
      errors++;
      $display("FAIL cnt_lookups_after_miss: got %0d required %0d", d, m_lookups);
    end
    api_read(12'h021, d, r);
    checks++;
    if (d !== 32'(m_hits)) begin
      errors++;
      $display("FAIL cnt_hits_after_miss: got %0d required %0d", d, m_hits);
    end
  endtask

  task automatic test_random_lookups();
    logic [KW-1:0] key;
    logic [31:0] d;
    logic r;
    int lat, idx, elat, eidx;
    bit hit, ok, ehit;
    for (int e = 0; e < N; e++) begin
      if (e != 5) begin
        stage(e, ($urandom_range(0, 3) != 0), rand_key());
        commit();
      end
    end
    stage(6, 1'b1, m_data[2]);
    commit();
    for (int n = 0; n < 16; n++) begin
      if (n == 0) key = m_data[2];
      else if ($urandom_range(0, 2) != 0) key = m_data[$urandom_range(0, N - 1)];
      else key = rand_key();
      model_lookup(key, ehit, eidx, elat);
      run_lookup(key, lat, hit, idx, ok);
      m_lookups++;
      if (ehit) m_hits++;
      checks++;
      if (!ok || lat !== elat || hit !== ehit || idx !== eidx) begin
        errors++;
        $display("FAIL rand_lookup[%0d]: got ok=%b lat=%0d hit=%b idx=%0d required lat=%0d hit=%b idx=%0d",
                 n, ok, lat, hit, idx, elat, ehit, eidx);
      end
      tick();
    end
    api_read(12'h020, d, r);
    checks++;
    if (d !== 32'(m_lookups)) begin
      errors++;
      $display("FAIL rand_cnt_lookups: got %0d required %0d", d, m_lookups);
    end
    api_read(12'h021, d, r);
    checks++;
    if (d !== 32'(m_hits)) begin
      errors++;
      $display("FAIL rand_cnt_hits: got %0d required %0d", d, m_hits);
    end
  endtask

  task automatic test_commit_during_scan();
    logic [KW-1:0] key_old, key_new;
    logic [31:0] d;
    logic r;
    int lat, idx, elat, eidx, t0;
    bit hit, ok, ehit;
    key_old = m_data[5];
    key_new = rand_key();
    stage(5, 1'b1, key_new);
    model_lookup(key_old, ehit, eidx, elat);
    bus.lookup_addr  = key_old;
    bus.lookup_start = 1'b1;
    t0 = cyc;
    tick();
    bus.lookup_start = 1'b0;
    api_write(12'h008, 32'h1);
    api_read(12'h009, d, r);
    checks++;
    if (d !== 32'h3) begin
      errors++;
      $display("FAIL status_pending_busy: got %h required 3", d);
    end
    ok = 1'b0; lat = 0; hit = 1'b0; idx = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (bus.lookup_done) begin
        ok = 1'b1; lat = cyc - t0; hit = bus.lookup_hit; idx = int'(bus.lookup_index);
      end else begin
        tick();
      end
    end
    m_lookups++;
    if (ehit) m_hits++;
    checks++;
    if (!ok || lat !== elat || hit !== ehit || idx !== eidx) begin
      errors++;
      $display("FAIL scan_uses_old_table: got ok=%b lat=%0d hit=%b idx=%0d required lat=%0d hit=%b idx=%0d",
               ok, lat, hit, idx, elat, ehit, eidx);
    end
    api_read(12'h128, d, r);
    checks++;
    if (d !== key_old[KW-1 -: 32]) begin
      errors++;
      $display("FAIL entry5_old_in_done: got %h required %h", d, key_old[KW-1 -: 32]);
    end
    tick();
    model_commit();
    api_read(12'h128, d, r);
    checks++;
    if (d !== key_new[KW-1 -: 32]) begin
      errors++;
      $display("FAIL entry5_new_after_done: got %h required %h", d, key_new[KW-1 -: 32]);
    end
    api_read(12'h009, d, r);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL status_after_copy: got %h required 0", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [KW-1:0] key;
    logic [31:0] d;
    logic r;
    int dones, elat, eidx;
    bit ehit;
    do begin
      key = rand_key();
      model_lookup(key, ehit, eidx, elat);
    end while (ehit);
    dones = 0;
    bus.lookup_addr = key;
    for (int k = 0; k < 15; k++) begin
      bus.lookup_start = (k <= N + 1);
      tick();
      if (bus.lookup_done) dones++;
    end
    bus.lookup_start = 1'b0;
    m_lookups++;
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d required 1", dones);
    end
    api_read(12'h020, d, r);
    checks++;
    if (d !== 32'(m_lookups)) begin
      errors++;
      $display("FAIL b2b_cnt_lookups: got %0d required %0d", d, m_lookups);
    end
  endtask

  task automatic test_clear_with_hit();
    logic [KW-1:0] key;
    logic [31:0] d;
    logic r;
    int elat, eidx, t0;
    bit ehit;
    key = m_data[5];
    model_lookup(key, ehit, eidx, elat);
    bus.lookup_addr  = key;
    bus.lookup_start = 1'b1;
    t0 = cyc;
    tick();
    bus.lookup_start = 1'b0;
    for (int k = 0; k < 40 && cyc < t0 + elat; k++) tick();
    checks++;
    if (bus.lookup_done !== 1'b1 || bus.lookup_hit !== 1'b1) begin
      errors++;
      $display("FAIL clear_hit_done: got done=%b hit=%b required 1 1", bus.lookup_done, bus.lookup_hit);
    end
    api_write(12'h008, 32'h2);
    m_lookups = 0;
    m_hits    = 0;
    api_read(12'h020, d, r);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL clear_cnt_lookups: got %0d required 0", d);
    end
    api_read(12'h021, d, r);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL clear_cnt_hits: got %0d required 0", d);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [KW-1:0] key;
    logic [31:0] d;
    logic r;
    int dones, lat, idx;
    bit hit, ok;
    key = rand_key();
    bus.lookup_addr  = key;
    bus.lookup_start = 1'b1;
    tick();
    bus.lookup_start = 1'b0;
    tick(); tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    model_reset();
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.lookup_done) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_abort_done: got %0d done pulses required 0", dones);
    end
    for (int e = 0; e < N; e++) begin
      api_read(12'h107 + 12'(8 * e), d, r);
      checks++;
      if (d !== 32'(m_valid[e])) begin
        errors++;
        $display("FAIL reset_valid[%0d]: got %h required %h", e, d, 32'(m_valid[e]));
      end
    end
    api_read(12'h140, d, r);
    checks++;
    if (d !== 32'hbeefbeef) begin
      errors++;
      $display("FAIL unmapped_entry8: got %h required beefbeef", d);
    end
    stage(9, 1'b1, key);
    commit();
    api_read(12'h00A, d, r);
    checks++;
    if (d !== 32'd9) begin
      errors++;
      $display("FAIL stage_index_rb: got %0d required 9", d);
    end
    for (int e = 0; e < N; e++) begin
      api_read(12'h107 + 12'(8 * e), d, r);
      checks++;
      if (d !== 32'(m_valid[e])) begin
        errors++;
        $display("FAIL oob_commit_valid[%0d]: got %h required %h", e, d, 32'(m_valid[e]));
      end
    end
    run_lookup(key, lat, hit, idx, ok);
    tick();
    checks++;
    if (!ok || lat !== N + 1 || hit !== 1'b0 || idx !== 0) begin
      errors++;
      $display("FAIL oob_commit_lookup: got ok=%b lat=%0d hit=%b idx=%0d required lat=%0d hit=0 idx=0",
               ok, lat, hit, idx, N + 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    areset           = 1'b1;
    bus.cs           = 1'b0;
    bus.we           = 1'b0;
    bus.address      = '0;
    bus.write_data   = '0;
    bus.lookup_start = 1'b0;
    bus.lookup_addr  = '0;
    model_reset();
    tick();
    test_reset();
    test_commit_hit();
    test_miss();
    test_random_lookups();
    test_commit_during_scan();
    test_back_to_back();
    test_clear_with_hit();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
